// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown controller: state encoding, datapath
// width and the button indices used for press priority resolution.
package countdown_pkg;

  localparam int VAL_W = 8;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int BTN_GO  = 2;
  localparam int NUM_BTN = 3;

  // Keep only the highest-priority press pulse: go > up > dn.
  function automatic logic [NUM_BTN-1:0] resolve_press(input logic [NUM_BTN-1:0] p);
    logic [NUM_BTN-1:0] r;
    r = {NUM_BTN{1'b0}};
    if (p[BTN_GO]) begin
      r[BTN_GO] = 1'b1;
    end else if (p[BTN_UP]) begin
      r[BTN_UP] = 1'b1;
    end else if (p[BTN_DN]) begin
      r[BTN_DN] = 1'b1;
    end else begin
      r = {NUM_BTN{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_ctrl_btn_cond.sv
// Button conditioner: 2-flop synchronizer, stability debouncer and a
// one-cycle pulse on each debounced press (releases produce nothing).
module btn_cond #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rs,
  input  logic raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous button into the clk domain; sync_r[1] is safe to use.
  always_ff @(posedge clk) begin
    if (rs) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Accept a new level only after it has differed from the current one for DB_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rs) begin
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else if (sync_r[1] == level_r) begin
      level_r <= level_r;
      cnt_r   <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      level_r <= sync_r[1];
      cnt_r   <= CNT_ZERO;
    end else begin
      level_r <= level_r;
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  // Registered one-cycle pulse on a debounced 0->1 transition.
  always_ff @(posedge clk) begin
    if (rs) begin
      level_d_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown controller: button-driven SET/RUN/PAUSE/DONE state machine over
// an 8-bit count, a tick prescaler and a display-refresh request handshake.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int INIT_VAL  = 21,
  parameter int MAX_VAL   = 99,
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             btn_go,
  output logic [VAL_W-1:0] value,
  output logic [1:0]       state,
  output logic             done,
  output logic             upd_req,
  input  logic             upd_ack
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [VAL_W-1:0] VAL_ZERO = {VAL_W{1'b0}};
  localparam logic [VAL_W-1:0] VAL_ONE  = VAL_W'(1);
  localparam logic [VAL_W-1:0] VAL_MAX  = VAL_W'(MAX_VAL);
  localparam logic [VAL_W-1:0] VAL_INIT = VAL_W'(INIT_VAL);

  logic [NUM_BTN-1:0] press_s;
  logic [NUM_BTN-1:0] act_s;
  logic               any_press_s;

  state_t             state_r;
  state_t             state_n_s;
  logic [VAL_W-1:0]   value_r;
  logic [VAL_W-1:0]   value_n_s;
  logic [PW-1:0]      presc_r;
  logic [PW-1:0]      presc_n_s;
  logic               done_r;
  logic               done_n_s;
  logic               upd_req_r;
  logic               changed_s;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_up (
    .clk(clk), .rs(rs), .raw(btn_up), .press(press_s[BTN_UP])
  );
  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_dn (
    .clk(clk), .rs(rs), .raw(btn_dn), .press(press_s[BTN_DN])
  );
  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_go (
    .clk(clk), .rs(rs), .raw(btn_go), .press(press_s[BTN_GO])
  );

  assign act_s       = resolve_press(press_s);
  assign any_press_s = |press_s;

  // Next state/value/prescaler. A RUN cycle always advances the prescaler,
  // even the one in which go pauses, so a pause/resume loses no RUN time.
  always_comb begin
    state_n_s = state_r;
    value_n_s = value_r;
    presc_n_s = presc_r;
    done_n_s  = 1'b0;
    case (state_r)
      ST_SET: begin
        if (act_s[BTN_GO]) begin
          if (value_r != VAL_ZERO) begin
            state_n_s = ST_RUN;
            presc_n_s = PRE_ZERO;
          end else begin
            state_n_s = ST_SET;
          end
        end else if (act_s[BTN_UP]) begin
          if (value_r < VAL_MAX) begin
            value_n_s = value_r + VAL_ONE;
          end else begin
            value_n_s = VAL_MAX;
          end
        end else if (act_s[BTN_DN]) begin
          if (value_r != VAL_ZERO) begin
            value_n_s = value_r - VAL_ONE;
          end else begin
            value_n_s = VAL_ZERO;
          end
        end else begin
          state_n_s = ST_SET;
        end
      end
      ST_RUN: begin
        if (presc_r == PRE_LAST) begin
          presc_n_s = PRE_ZERO;
          value_n_s = value_r - VAL_ONE;
          if (value_r == VAL_ONE) begin
            state_n_s = ST_DONE;
            done_n_s  = 1'b1;
          end else if (act_s[BTN_GO]) begin
            state_n_s = ST_PAUSE;
          end else begin
            state_n_s = ST_RUN;
          end
        end else begin
          presc_n_s = presc_r + PRE_ONE;
          if (act_s[BTN_GO]) begin
            state_n_s = ST_PAUSE;
          end else begin
            state_n_s = ST_RUN;
          end
        end
      end
      ST_PAUSE: begin
        if (act_s[BTN_GO]) begin
          state_n_s = ST_RUN;
        end else if (act_s[BTN_DN]) begin
          state_n_s = ST_SET;
        end else begin
          state_n_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (any_press_s) begin
          state_n_s = ST_SET;
          value_n_s = VAL_INIT;
        end else begin
          state_n_s = ST_DONE;
        end
      end
      default: begin
        state_n_s = ST_SET;
        value_n_s = VAL_INIT;
        presc_n_s = PRE_ZERO;
      end
    endcase
  end

  assign changed_s = (state_n_s != state_r) || (value_n_s != value_r);

  // Controller registers; a change always wins over an ack so no redraw is lost.
  always_ff @(posedge clk) begin
    if (rs) begin
      state_r   <= ST_SET;
      value_r   <= VAL_INIT;
      presc_r   <= PRE_ZERO;
      done_r    <= 1'b0;
      upd_req_r <= 1'b1;
    end else begin
      state_r   <= state_n_s;
      value_r   <= value_n_s;
      presc_r   <= presc_n_s;
      done_r    <= done_n_s;
      if (changed_s) begin
        upd_req_r <= 1'b1;
      end else if (upd_ack) begin
        upd_req_r <= 1'b0;
      end else begin
        upd_req_r <= upd_req_r;
      end
    end
  end

  assign value   = value_r;
  assign state   = state_r;
  assign done    = done_r;
  assign upd_req = upd_req_r;

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown controller for the Spartan-3E LCD kit. It conditions three push-buttons and owns one 8-bit count register: the user sets it up or down, starts, pauses and resumes it, and it counts down at a fixed tick rate. A request/acknowledge pair tells the LCD writer when `value`/`state` has changed and the display must be redrawn.

## Interface
- `INIT_VAL`, 21: value loaded at reset and on leaving DONE.
- `MAX_VAL`, 99: upper saturation limit in SET.
- `TICK_DIV`, 50_000_000: clk cycles per countdown tick (1 s at 50 MHz); must be ≥ 2.
- `DB_CYCLES`, 500_000: cycles a synchronized button must be stable before it is accepted; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rs`  in  1  reset; one clock, synchronous, active-high.
- `btn_up`  in  1  raw button, asynchronous, active-high.
- `btn_dn`  in  1  raw button, asynchronous, active-high.
- `btn_go`  in  1  raw button, asynchronous, active-high; start/pause/resume.
- `value`  out  8  current count, unsigned binary.
- `state`  out  2  SET=0, RUN=1, PAUSE=2, DONE=3.
- `done`  out  1  one-cycle pulse when the count reaches 0.
- `upd_req`  out  1  display refresh request.
- `upd_ack`  in  1  LCD writer acknowledge, synchronous to `clk`.

## Operation
- Each button passes through a 2-flop synchronizer and a debouncer. The debounced level changes only after the synchronized input has differed from it for DB_CYCLES consecutive cycles.
- A debounced 0→1 transition produces a one-cycle press pulse. Releases are ignored.
- Simultaneous presses: go > up > dn. Only the highest-priority pulse acts; the others are dropped.
- SET:
  - up: `value`+1, saturating at MAX_VAL.
  - dn: `value`−1, saturating at 0.
  - go: enter RUN if `value`≠0; if `value`=0, ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV−1. At TICK_DIV−1 it wraps and `value` decrements.
  - A decrement to 0 enters DONE and pulses `done` in the same cycle.
  - go: enter PAUSE; the prescaler is frozen (not cleared).
  - up/dn: ignored.
- PAUSE:
  - go: return to RUN; the prescaler resumes from its frozen count.
  - dn: return to SET with `value` retained.
  - up: ignored.
- DONE: any press → SET, `value`=INIT_VAL.
- Entering RUN from SET clears the prescaler to 0.
- `upd_req`:
  - Set on any cycle in which `value` or `state` changes.
  - Cleared on a cycle with `upd_ack`=1 and no new change.
  - A change in the same cycle as `upd_ack` keeps it high, so updates coalesce and none are lost.
- `rs` takes priority over everything. Reset mid-RUN or mid-debounce discards all in-flight state.

## Timing
- Reset values:
  - `value`=INIT_VAL, `state`=SET, `done`=0.
  - `upd_req`=1, so the initial value gets drawn.
  - Prescaler 0; synchronizers and debounced levels 0.
- Press latency: a raw edge seen at clock k yields the press pulse at k+2+DB_CYCLES. `value`/`state` update at the following edge; `upd_req` rises on the same edge as that update.
- Tick spacing in uninterrupted RUN is exactly TICK_DIV cycles. The first decrement comes TICK_DIV cycles after the RUN-entry edge.
- `done` is high for exactly one cycle, on the cycle `state` becomes DONE.
- `upd_ack` may arrive any number of cycles after `upd_req`. A held `upd_ack` with no changes keeps `upd_req` low.
- Every output is a register; there are no combinational paths from inputs to outputs.

## Structure
- Package `countdown_pkg`:
  - state encoding constants (SET/RUN/PAUSE/DONE);
  - value width (8);
  - button index constants (UP/DN/GO) used for priority resolution.
- Sub-module `btn_cond`, instantiated three times:
  - ports `clk`, `rs`, `raw`, `press`;
  - parameter DB_CYCLES;
  - contains the synchronizer, debounce counter and rising-edge pulse.
- The top level holds the FSM, value register, prescaler and update handshake.

## Test plan
Simulation uses DB_CYCLES=4, TICK_DIV=10, INIT_VAL=21, MAX_VAL=99.
- Reset → `value`=21, `state`=0, `upd_req`=1. Pulse `upd_ack` → `upd_req`=0 the next cycle.
- dn held 3 cycles, then released → no change. dn held 10 cycles → exactly one decrement to 20. Bouncing input (1/0 alternating, 8 cycles) → no change.
- Saturation: from 98, press up 3× → 99 and stays 99. Set 0, press dn → stays 0. Press go at 0 → state stays SET.
- Countdown: set 3, press go → state RUN. Values 2, 1, 0 at 10-cycle spacing. `done` high 1 cycle as state becomes DONE. Press up → SET with `value`=21.
- Pause/resume: in RUN at prescaler 6, press go → PAUSE with value frozen for 50 cycles. Press go → next tick 3 cycles after re-entry to RUN. Then go, dn → SET with value retained.
- Simultaneous up+go in SET → RUN entered and value unchanged. Assert `rs` mid-RUN → reset values next cycle. Change coincident with `upd_ack` → `upd_req` stays 1.
